tap_delay_line: RTL and testbench
=================================

Name: tap_delay_line

Overview:
- Synthesisable, parametrised successor to the delta-delay experiments: an explicit, cycle-accurate delay line replacing ad-hoc zero-time assignment chains.
- Delays CHANNELS independent WIDTH-bit lanes by a run-time selectable number of clock cycles.
- Provides a line-primed status and a per-lane change-detect pulse.
- Used in sim-best-practice benches and datapaths that need known, alignable latency instead of relying on simulator event ordering.

Parameters:
- WIDTH, 8, bits per lane.
- CHANNELS, 4, number of parallel lanes.
- DEPTH, 16, number of storage stages; the maximum delay.
- SEL_W, 4, width of delay_sel; must satisfy 2**SEL_W >= DEPTH.

Ports:
- clk  in  1  single clock; rising-edge active.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  advance enable; the line shifts only when en=1.
- flush  in  1  synchronous clear of stored valid bits.
- delay_sel  in  SEL_W  requested delay minus 1; effective delay is delay_sel+1 cycles.
- din  in  CHANNELS*WIDTH  packed lane data; lane k is bits [k*WIDTH +: WIDTH].
- din_vld  in  1  qualifies din.
- dout  out  CHANNELS*WIDTH  delayed lane data.
- dout_vld  out  1  delayed din_vld, gated by primed.
- primed  out  1  line has been filled to the current delay since the last reset, flush or delay change.
- chg  out  CHANNELS  one-cycle pulse per lane when that lane's dout differs from its previous dout while dout_vld=1.

Behaviour:
- Reset (reset_n=0 at a rising clk edge):
  - all stages, dout, dout_vld, primed and chg go to 0.
  - State machine goes to FILL with fill_cnt=0.
  - Reset wins over every other input.
- Storage: DEPTH-stage shift register of {din_vld, din}. On en=1, stage0<=input and stage[i]<=stage[i-1]. On en=0, all stages hold and chg=0.
- Output tap:
  - dout and the raw valid are registered from stage[delay_sel].
  - Latency from din sampled to dout equals delay_sel+1 enabled cycles.
  - delay_sel=0 gives 1 cycle.
  - delay_sel >= DEPTH is clamped to DEPTH-1.
- FSM, two states:
  - FILL: on each en cycle, fill_cnt++. When fill_cnt == clamped delay_sel, go to RUN and set primed=1 on the same edge.
  - RUN: primed=1. Any change of delay_sel (compared against a registered copy) or flush=1 returns the FSM to FILL, clears fill_cnt and primed.
- dout_vld = raw tap valid AND primed. Data is still presented while in FILL.
- flush=1 clears the valid bit of every stage and dout_vld in the same edge. Data bits are not cleared.
  - flush together with en: the new input is also discarded, i.e. stage0 valid=0.
- chg[k]:
  - Registered: 1 when en=1, the new dout_vld=1, the previous dout_vld=1, and lane k differs from the previous value.
  - The first valid sample after a gap never pulses.
- Width: fill_cnt is SEL_W+1 bits and saturates at DEPTH.
- The block has no combinational path from any input to any output.

Decomposition:
- Shared package `tdl_pkg`:
  - FSM state encoding (FILL=1'b0, RUN=1'b1).
  - A clamp function for delay_sel.
  - The lane-slice helper function.
- One natural sub-module, `tdl_lane_chg`: a per-lane change detector holding the previous value and previous valid. Instantiate it CHANNELS times via generate.
- Shift register and tap mux stay in the top module.

Test Plan:
1. Reset, then delay_sel=0 and en=1. Drive lane0=8'h11 with din_vld=1 in cycle 0.
   - Required: dout lane0=8'h11 with dout_vld=1 in cycle 1.
   - Required: primed rises at the first en edge after reset.
2. delay_sel=5, continuous en, incrementing data 1,2,3…
   - Required: primed asserts after 6 enabled cycles.
   - Required: dout trails din by exactly 6 cycles.
   - Required: chg=4'hF every cycle once dout_vld=1.
3. en toggled 1,0,1,0 with delay_sel=3.
   - Required: latency counts only enabled cycles; dout holds and chg=0 on en=0 cycles.
4. In RUN with delay_sel=3, switch delay_sel to 7.
   - Required: primed and dout_vld drop on the next edge and reassert after 8 enabled cycles.
   - Required: no chg pulse at the first new valid sample.
5. Mid-stream flush=1 for one cycle with en=1.
   - Required: dout_vld=0 from the next edge until the line refills (delay_sel+1 cycles).
   - Required: the input sample accompanying flush never appears valid.
6. delay_sel=15 with DEPTH=16, then delay_sel forced to 20 (SEL_W=5 build).
   - Required: both give 16-cycle latency (clamped).
   - Required: reset_n=0 mid-fill clears dout, dout_vld, primed and chg in the next cycle.

Source files
------------

// File: rtl/tdl_pkg.sv
// Shared types and helpers for the tap delay line.
package tdl_pkg;

  typedef enum logic {
    StFill = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Out-of-range delay requests fall back to the deepest tap.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned depth);
    return (sel >= depth) ? depth - 1 : sel;
  endfunction

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/tdl_lane_chg.sv
// Per-lane change detector: pulses when a valid sample differs from the previous valid one.
module tdl_lane_chg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] new_data,
  input  logic             new_vld,
  output logic             chg
);

  logic [WIDTH-1:0] prev_q;
  logic             prev_vld_q;
  logic             chg_q;
  logic             chg_d;

  assign chg_d = en & new_vld & prev_vld_q & (new_data != prev_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      prev_q     <= new_data;
      prev_vld_q <= new_vld;
      chg_q      <= chg_d;
    end
  end

  assign chg = chg_q;

endmodule

// File: rtl/tap_delay_line.sv
// Multi-lane delay line with run-time selectable latency, primed status and change pulses.
module tap_delay_line
  import tdl_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SEL_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      flush,
  input  logic [SEL_W-1:0]          delay_sel,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      din_vld,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_vld,
  output logic                      primed,
  output logic [CHANNELS-1:0]       chg
);

  localparam int unsigned DW   = CHANNELS * WIDTH;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = SEL_W + 1;

  // Each entry is {valid, data}. The output register is the last stage, so tap[0] is the input.
  logic [DW:0]      stage_q [DEPTH-1];
  logic [DW:0]      tap     [DEPTH];
  logic [IdxW-1:0]  sel_c;
  logic [DW-1:0]    dout_q, dout_d;
  logic             raw_vld_q, raw_vld_d;
  state_e           state_q, state_d;
  logic [CntW-1:0]  fill_cnt_q, fill_cnt_d;
  logic [SEL_W-1:0] sel_q;
  logic             restart;
  logic             new_vld;

  assign sel_c = IdxW'(clamp_sel(32'(delay_sel), DEPTH));

  always_comb begin
    tap[0] = {din_vld & ~flush, din};
    for (int i = 1; i < DEPTH; i++) begin
      tap[i] = stage_q[i-1];
    end
  end

  // Flush drops valid bits everywhere but leaves the data in place.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stage_q[i] <= {tap[i][DW] & ~flush, tap[i][DW-1:0]};
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stage_q[i][DW] <= 1'b0;
      end
    end
  end

  always_comb begin
    dout_d    = dout_q;
    raw_vld_d = raw_vld_q;
    if (en) begin
      dout_d    = tap[sel_c][DW-1:0];
      raw_vld_d = tap[sel_c][DW] & ~flush;
    end else if (flush) begin
      raw_vld_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    restart    = flush | (delay_sel != sel_q);
    if (restart) begin
      state_d    = StFill;
      fill_cnt_d = '0;
    end else if (en) begin
      if (fill_cnt_q != CntW'(DEPTH)) begin
        fill_cnt_d = fill_cnt_q + CntW'(1);
      end
      if (state_q == StFill && fill_cnt_q == CntW'(sel_c)) begin
        state_d = StRun;
      end
    end
  end

  // sel_q tracks delay_sel even in reset so a stable selection is not seen as a change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StFill;
      fill_cnt_q <= '0;
      sel_q      <= delay_sel;
      dout_q     <= '0;
      raw_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      sel_q      <= delay_sel;
      dout_q     <= dout_d;
      raw_vld_q  <= raw_vld_d;
    end
  end

  assign primed   = (state_q == StRun);
  assign dout     = dout_q;
  assign dout_vld = raw_vld_q & primed;
  assign new_vld  = raw_vld_d & (state_d == StRun);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    localparam int unsigned Lo = lane_lo(k, WIDTH);
    tdl_lane_chg #(
      .WIDTH(WIDTH)
    ) u_chg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .new_data(dout_d[Lo +: WIDTH]),
      .new_vld (new_vld),
      .chg     (chg[k])
    );
  end

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: directed scenarios plus random traffic against a history-based model.
module tb_tap_delay_line;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned SEL_W    = 5;
  localparam int unsigned DW       = WIDTH * CHANNELS;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                en = 1'b0;
  logic                flush = 1'b0;
  logic [SEL_W-1:0]    delay_sel = '0;
  logic [DW-1:0]       din = '0;
  logic                din_vld = 1'b0;
  logic [DW-1:0]       dout;
  logic                dout_vld;
  logic                primed;
  logic [CHANNELS-1:0] chg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tap_delay_line #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .DEPTH   (DEPTH),
    .SEL_W   (SEL_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .flush    (flush),
    .delay_sel(delay_sel),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .primed   (primed),
    .chg      (chg)
  );

  // Reference: hist[j] is the sample accepted j enabled edges ago (0 = this edge).
  logic [DW:0]         hist [DEPTH];
  logic [DW-1:0]       m_dout;
  logic                m_raw, m_dout_vld, m_primed;
  logic [CHANNELS-1:0] m_chg;
  int                  m_k;
  logic [SEL_W-1:0]    m_sel_prev;

  always @(posedge clk) begin : model
    int            c;
    logic          old_v;
    logic [DW-1:0] old_d;
    logic          restart;
    c = (int'(delay_sel) >= int'(DEPTH)) ? int'(DEPTH) - 1 : int'(delay_sel);
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) hist[i] = '0;
      m_dout = '0; m_raw = 1'b0; m_k = 0; m_primed = 1'b0;
      m_dout_vld = 1'b0; m_chg = '0; m_sel_prev = delay_sel;
    end else begin
      old_v   = m_dout_vld;
      old_d   = m_dout;
      restart = flush || (delay_sel != m_sel_prev);
      if (flush) for (int i = 0; i < DEPTH; i++) hist[i][DW] = 1'b0;
      if (en) begin
        for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {din_vld && !flush, din};
        m_dout  = hist[c][DW-1:0];
        m_raw   = hist[c][DW];
      end else if (flush) begin
        m_raw = 1'b0;
      end
      if (restart) m_k = 0;
      else if (en && m_k < int'(DEPTH)) m_k = m_k + 1;
      m_primed   = (m_k >= c + 1);
      m_dout_vld = m_raw && m_primed;
      for (int l = 0; l < CHANNELS; l++)
        m_chg[l] = en && m_dout_vld && old_v && (m_dout[l*WIDTH +: WIDTH] != old_d[l*WIDTH +: WIDTH]);
      m_sel_prev = delay_sel;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    n_vec++;
    if (dout !== m_dout || dout_vld !== m_dout_vld || primed !== m_primed || chg !== m_chg) begin
      n_err++;
      $display("FAIL model @%0t: dout %h want %h, dout_vld %b want %b, primed %b want %b, chg %h want %h",
               $time, dout, m_dout, dout_vld, m_dout_vld, primed, m_primed, chg, m_chg);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v);
    din     = {CHANNELS{v}};
    din_vld = 1'b1;
  endtask

  initial begin
    int         edges;
    logic [7:0] v;
    bit         seen_bad;

    // Reset state, then one-cycle delay
    reset_n = 1'b0; delay_sel = '0;
    step(); step();
    check("rst_dout", dout, 32'h0);
    check("rst_dout_vld", dout_vld, 0);
    check("rst_primed", primed, 0);
    check("rst_chg", chg, 0);
    reset_n = 1'b1; en = 1'b1; din = 32'h11; din_vld = 1'b1;
    step();
    check("t1_dout", dout[7:0], 8'h11);
    check("t1_dout_vld", dout_vld, 1);
    check("t1_primed", primed, 1);

    // delay_sel=5, continuous stream
    reset_n = 1'b0; delay_sel = 5'd5; step(); reset_n = 1'b1;
    edges = 0; v = 0;
    while (!primed && edges < 40) begin
      v++; drive(v); step(); edges++;
    end
    check("t2_prime_edges", edges, 6);
    check("t2_first_dout", dout[7:0], 8'd1);
    for (int i = 0; i < 3; i++) begin
      v++; drive(v); step();
    end
    check("t2_chg", chg, 4'hF);
    check("t2_trail", dout[7:0], v - 8'd5);

    // Alternating enable, delay_sel=3
    reset_n = 1'b0; delay_sel = 5'd3; step(); reset_n = 1'b1;
    v = 0; edges = 0;
    for (int i = 0; i < 12; i++) begin
      en = (i % 2 == 0);
      if (en) begin
        v++; drive(v);
      end
      step();
      if (en) edges++;
      check("t3_dout", dout[7:0], (edges >= 4) ? 8'(edges - 3) : 8'd0);
      if (!en) check("t3_chg_idle", chg, 0);
      if (en && edges == 4) check("t3_primed", primed, 1);
    end

    // Switch delay 3 -> 7 while running
    en = 1'b1; delay_sel = 5'd7; v++; drive(v);
    step();
    check("t4_primed_drop", primed, 0);
    check("t4_vld_drop", dout_vld, 0);
    edges = 0;
    while (!primed && edges < 40) begin
      v++; drive(v); step(); edges++;
    end
    check("t4_reprime_edges", edges, 8);
    check("t4_vld_back", dout_vld, 1);
    check("t4_no_chg", chg, 0);

    // One-cycle flush carrying a marker sample that must never emerge valid
    for (int i = 0; i < 3; i++) begin
      v++; drive(v & 8'h7F); step();
    end
    flush = 1'b1; drive(8'hAA);
    step();
    flush = 1'b0;
    check("t5_vld_drop", dout_vld, 0);
    edges = 0; seen_bad = 1'b0;
    while (!dout_vld && edges < 40) begin
      v++; drive(v & 8'h7F); step(); edges++;
      if (dout_vld && dout[7:0] == 8'hAA) seen_bad = 1'b1;
    end
    check("t5_refill_edges", edges, 8);
    for (int i = 0; i < 20; i++) begin
      v++; drive(v & 8'h7F); step();
      if (dout_vld && dout[7:0] == 8'hAA) seen_bad = 1'b1;
    end
    check("t5_marker_hidden", seen_bad, 0);

    // Deepest tap, then an out-of-range request that clamps to it
    reset_n = 1'b0; delay_sel = 5'd15; step(); reset_n = 1'b1;
    edges = 0; v = 0;
    while (!dout_vld && edges < 40) begin
      v++; drive(v); step(); edges++;
    end
    check("t6_lat15", edges, 16);
    delay_sel = 5'd20; v++; drive(v);
    step();
    check("t6_change_drop", dout_vld, 0);
    edges = 0;
    while (!dout_vld && edges < 40) begin
      v++; drive(v); step(); edges++;
    end
    check("t6_lat20", edges, 16);
    check("t6_dout20", dout[7:0], v - 8'd15);
    delay_sel = 5'd9;
    for (int i = 0; i < 5; i++) begin
      v++; drive(v); step();
    end
    reset_n = 1'b0;
    step();
    check("t6_rst_dout", dout, 32'h0);
    check("t6_rst_vld", dout_vld, 0);
    check("t6_rst_primed", primed, 0);
    check("t6_rst_chg", chg, 0);
    reset_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      en      = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) delay_sel = SEL_W'($urandom_range(0, 31));
      din     = DW'($urandom());
      din_vld = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
